memory_access_unit: RTL
=======================

Name: memory_access_unit

Overview:
- Data-memory stage directly downstream of the execute stage in the LEGv8 datapath.
- Consumes the ALU result as the effective address and read_data2 as store data.
- Runs the load/store transaction to data memory over a req/ack bus, then returns aligned, extended load data to write-back.
- Holds the datapath with busy until the access completes, faults, or times out.

Parameters:
WORD, 64, datapath and memory bus width in bits (fixed 64 for LEGv8)
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before a bus error (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: new instruction's memory phase begins; sampled only in IDLE
mem_read  input  1  load instruction
mem_write  input  1  store instruction
mem_size  input  2  00 byte, 01 half, 10 word, 11 doubleword
load_signed  input  1  sign-extend load result (LDURSW); 0 = zero-extend
address  input  WORD  effective address from the execute-stage ALU result
write_data  input  WORD  store data, low bits significant
read_data  output  WORD  extended load result; valid while done=1, held until next start
done  output  1  one-cycle completion pulse
busy  output  1  high from the cycle after start until done, inclusive
align_fault  output  1  access not naturally aligned; valid with done
bus_error  output  1  ack timeout; valid with done
mem_req  output  1  bus request, registered
mem_we  output  1  1 = write, registered
mem_addr  output  WORD  doubleword-aligned bus address {address[63:3],3'b000}
mem_wdata  output  WORD  store data shifted to byte lane
mem_wstrb  output  8  byte enables, write only; 0 on reads
mem_rdata  input  WORD  read data, sampled when mem_ack=1
mem_ack  input  1  bus completion, one cycle

Behaviour:
- Reset: state IDLE. mem_req, mem_we, done, busy, align_fault and bus_error are 0. read_data, mem_addr, mem_wdata and mem_wstrb are 0. Timer is 0.
- Reset mid-transaction aborts immediately. mem_req drops the next cycle and no done is produced.
- Alignment:
  - Half requires address[0]=0.
  - Word requires address[1:0]=0.
  - Doubleword requires address[2:0]=0.
  - Byte is always aligned.
- Lane: L=address[2:0].
- Writes:
  - mem_wdata = write_data << 8L.
  - mem_wstrb = (size mask 0x01/0x03/0x0F/0xFF) << L.
- Reads:
  - read_data = (mem_rdata >> 8L) masked to the size.
  - The result is sign-extended from the size's MSB if load_signed=1, else zero-extended.
  - load_signed is ignored for doubleword.
- mem_read and mem_write both high: treat as write. Flags are latched at start and input changes afterwards are ignored.
- FSM:
  - IDLE, start, neither flag set: go to DONE. No bus activity. read_data and faults are 0.
  - IDLE, start, misaligned: go to DONE with align_fault=1. No request. read_data is 0.
  - IDLE, start, aligned: latch all inputs and go to WAIT. mem_req=1 from the next cycle; mem_we, mem_addr, mem_wdata and mem_wstrb are valid with it.
  - WAIT:
    - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay constant and high/valid.
    - The timer increments each cycle.
    - If mem_ack=1: capture and extract mem_rdata (reads), drop mem_req the next cycle, go to DONE.
    - Else if the timer reaches TIMEOUT-1: drop mem_req, set bus_error=1, set read_data=0, go to DONE.
    - mem_ack on the timeout cycle wins: normal completion.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=1. The timer clears.
- Latency: ack in the first request cycle gives done two cycles after start. Each ack-wait cycle adds one.
- start while busy=1 is ignored. start in the same cycle as done's IDLE return is not possible: the unit reaches IDLE the cycle after done. mem_ack outside WAIT is ignored.
- align_fault and bus_error clear on the next start.

Test Plan:
- LDUR: address 0x1000, size 11, ack after 3 wait cycles with mem_rdata 0x1122334455667788.
  - Response: mem_addr 0x1000, mem_wstrb 0x00, done at start+5, read_data 0x1122334455667788, busy high 5 cycles.
- LDURB signed: address 0x2005, mem_rdata 0x0000_9A00_0000_0000, load_signed=1, immediate ack.
  - Response: mem_addr 0x2000, read_data 0xFFFF_FFFF_FFFF_FF9A, done at start+2.
  - Same case with load_signed=0 gives 0x9A.
- STURH: address 0x3006, write_data 0xABCD.
  - Response: mem_we=1, mem_wstrb 0xC0, mem_wdata 0xABCD_0000_0000_0000, mem_addr 0x3000.
- Misaligned LDURSW: address 0x4002.
  - Response: mem_req never rises, done at start+1, align_fault=1, read_data 0.
- Timeout: no ack, TIMEOUT=16.
  - Response: mem_req high 16 cycles, then done with bus_error=1.
  - A second start pulse sent during WAIT is ignored.
- Reset asserted in the 2nd WAIT cycle.
  - Response: all outputs 0 the next cycle, no done pulse.
  - A following start behaves normally.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit: LEGv8 data-memory stage driving a req/ack bus with alignment, lane steering and load extension
module memory_access_unit #(
  parameter int WORD    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            load_signed,
  input  logic [WORD-1:0] address,
  input  logic [WORD-1:0] write_data,
  output logic [WORD-1:0] read_data,
  output logic            done,
  output logic            busy,
  output logic            align_fault,
  output logic            bus_error,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ack
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t          state;
  logic [TW-1:0]   timer;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [2:0]      lane_q;
  logic            misaligned;
  logic [7:0]      mask;
  logic [WORD-1:0] rsh;
  logic [WORD-1:0] rext;
  always_comb begin
    misaligned = mem_size == 2'd1 ? address[0] :
                 mem_size == 2'd2 ? |address[1:0] :
                 mem_size == 2'd3 ? |address[2:0] : 1'b0;
    mask = mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF;
    rsh  = mem_rdata >> {lane_q, 3'b000};
    rext = size_q == 2'd0 ? {{(WORD-8){signed_q & rsh[7]}}, rsh[7:0]} :
           size_q == 2'd1 ? {{(WORD-16){signed_q & rsh[15]}}, rsh[15:0]} :
           size_q == 2'd2 ? {{(WORD-32){signed_q & rsh[31]}}, rsh[31:0]} : rsh;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      read_data   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      align_fault <= 1'b0;
      bus_error   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          read_data   <= '0;
          bus_error   <= 1'b0;
          busy        <= 1'b1;
          timer       <= '0;
          if (!(mem_read || mem_write) || misaligned) begin
            align_fault <= (mem_read || mem_write) && misaligned;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            align_fault <= 1'b0;
            size_q      <= mem_size;
            signed_q    <= load_signed;
            lane_q      <= address[2:0];
            mem_req     <= 1'b1;
            mem_we      <= mem_write;
            mem_addr    <= {address[WORD-1:3], 3'b000};
            mem_wdata   <= mem_write ? write_data << {address[2:0], 3'b000} : '0;
            mem_wstrb   <= mem_write ? mask << address[2:0] : 8'h00;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // ack on the final timer cycle still completes normally
          if (mem_ack || timer == TW'(TIMEOUT - 1)) begin
            read_data <= (mem_ack && !mem_we) ? rext : '0;
            bus_error <= !mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b1;
            timer     <= '0;
            state     <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
